// File: rtl/sequence_ctrl.sv
// sequence_ctrl: record/playback controller for the 2-bit sequencer.
// Conditions panel buttons, writes the sequence RAM and paces playback.
module sequence_ctrl #(
  parameter int unsigned COUNTER_LIMIT = 5,
  parameter logic [23:0] CLOCK_LIMIT   = 24'd5999999,
  parameter int unsigned ADDR_WIDTH    = 3
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  Store,
  input  logic                  Play,
  input  logic [1:0]            Sequence,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [1:0]            mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   length,
  output logic                  full,
  output logic                  empty,
  output logic                  display_en,
  output logic                  tick
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] CAP = LW'(COUNTER_LIMIT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e                state_q;
  logic [2:0]            store_sync_q;
  logic [2:0]            play_sync_q;
  logic [1:0]            seq_s1_q;
  logic [1:0]            seq_s2_q;
  logic                  store_p_q;
  logic                  play_p_q;
  logic [23:0]           cnt_q;
  logic [LW-1:0]         length_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [1:0]            wdata_q;
  logic                  we_q;
  logic                  wrap;
  logic                  last;
  logic                  is_full;

  assign wrap    = (state_q == PLAY) && (cnt_q == CLOCK_LIMIT);
  assign last    = ({1'b0, raddr_q} == (length_q - 1'b1));
  assign is_full = (length_q == CAP);

  // [0],[1] synchronise the pin, [2] is the previous level for edge detect
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      store_sync_q <= '1;
      play_sync_q  <= '1;
      seq_s1_q     <= '1;
      seq_s2_q     <= '1;
      store_p_q    <= 1'b0;
      play_p_q     <= 1'b0;
    end else begin
      store_sync_q <= {store_sync_q[1:0], Store};
      play_sync_q  <= {play_sync_q[1:0], Play};
      seq_s1_q     <= Sequence;
      seq_s2_q     <= seq_s1_q;
      store_p_q    <= store_sync_q[2] & ~store_sync_q[1];
      play_p_q     <= play_sync_q[2] & ~play_sync_q[1];
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      length_q <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (store_p_q && !is_full) begin
        we_q     <= 1'b1;
        waddr_q  <= length_q[ADDR_WIDTH-1:0];
        wdata_q  <= ~seq_s2_q;
        length_q <= length_q + 1'b1;
      end
      // a store in the same cycle swallows the play press
      if (play_p_q && !store_p_q) begin
        cnt_q   <= '0;
        raddr_q <= '0;
        if (state_q == PLAY) begin
          state_q <= IDLE;
        end else if (length_q != '0) begin
          state_q <= PLAY;
        end
      end else if (state_q == PLAY) begin
        if (wrap) begin
          cnt_q   <= '0;
          raddr_q <= last ? '0 : raddr_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_raddr  = raddr_q;
  assign length     = length_q;
  assign full       = is_full;
  assign empty      = (length_q == '0);
  assign display_en = (state_q == PLAY);
  assign tick       = wrap;

endmodule

// File: doc/sequence_ctrl.md
# sequence_ctrl

Record/playback controller for the 2-bit sequencer datapath. It synchronises the active-low Store, Play and Sequence front-panel inputs. It issues write strobes, addresses and data to the sequence memory, tracks the stored length, and paces playback with a CLOCK_LIMIT tick that steps the read address through the stored entries. It sits between the board pins and the sequence RAM/display path.

## Interface

- COUNTER_LIMIT, 5: highest memory index; capacity = COUNTER_LIMIT+1 entries.
- CLOCK_LIMIT, 24'd5999999: tick period minus one, in clocks.
- ADDR_WIDTH, 3: memory address width; must satisfy 2^ADDR_WIDTH >= COUNTER_LIMIT+1.
- clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Store  in  1  store button, active-low, asynchronous to clock.
- Play  in  1  play/stop button, active-low, asynchronous.
- Sequence  in  2  value switches, active-low, asynchronous.
- mem_we  out  1  one-cycle memory write strobe.
- mem_waddr  out  ADDR_WIDTH  write address.
- mem_wdata  out  2  write data (true polarity).
- mem_raddr  out  ADDR_WIDTH  playback read address.
- length  out  ADDR_WIDTH+1  number of stored entries.
- full  out  1  length == COUNTER_LIMIT+1.
- empty  out  1  length == 0.
- display_en  out  1  high while in PLAY.
- tick  out  1  one-cycle pulse at each playback step.

## Operation

- Input conditioning:
  - Store, Play and Sequence each pass through a 2-flop synchroniser and are inverted.
  - A third register edge-detects Store and Play. A press (pin high->low) yields store_p / play_p for exactly one cycle.
  - No debounce.
- States: IDLE (reset), PLAY.
- Store (accepted in either state):
  - If store_p and !full: mem_we=1, mem_waddr=length, mem_wdata=synchronised Sequence; length increments.
  - If full: store_p is ignored; no strobe, length unchanged.
- Play:
  - play_p in IDLE with length>0: go to PLAY, mem_raddr=0, tick counter=0.
  - play_p in IDLE with length==0: ignored.
  - play_p in PLAY: go to IDLE, mem_raddr=0, counter=0.
- Simultaneous store_p and play_p: store is processed; play_p is dropped.
- In PLAY:
  - Tick counter counts 0..CLOCK_LIMIT, then wraps to 0. tick=1 in the wrap cycle.
  - On each wrap, mem_raddr increments. It returns to 0 when mem_raddr == length-1, using length as registered at that edge.
- Store during PLAY appends at index length. The wrap point extends from the next tick onward.
- In IDLE the counter is held at 0 and tick=0.
- Reset values (all outputs): mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, length=0, full=0, empty=1, display_en=0, tick=0, state IDLE. The counter and synchroniser/edge registers are cleared; synchroniser flops reset to the released (high-pin) level, so no spurious press follows reset.

## Timing

- Pin-to-pulse latency: a pin falling before edge N gives store_p/play_p high in the cycle after edge N+2.
- store_p registered high: at the next edge, mem_we/mem_waddr/mem_wdata are valid for exactly one cycle. length, full and empty update on that same edge.
- play_p: state, display_en and mem_raddr=0 update on the next edge.
- Playback:
  - Step period is CLOCK_LIMIT+1 clocks.
  - The first tick occurs CLOCK_LIMIT+1 clocks after PLAY entry.
  - mem_raddr changes on the edge ending the tick cycle.
- Reset is asynchronous: asserting Reset low mid-PLAY or mid-write forces all reset values immediately, independent of clock. Deassertion takes effect at the next clock edge.

## Test plan

All scenarios use COUNTER_LIMIT=5, CLOCK_LIMIT=3.

- **Reset:** hold Reset low during active PLAY with length=3 -> immediately display_en=0, mem_raddr=0, length=0, empty=1, mem_we=0; no pulse on release.
- **Record:** press Store with Sequence pins = ~2, ~1, ~3 -> three single-cycle mem_we pulses with (waddr, wdata) = (0,2), (1,1), (2,3); length=3; each pulse exactly 4 clocks after the pin falls.
- **Playback:** after record, press Play -> display_en=1; tick every 4 clocks; mem_raddr sequence 0,1,2,0,1; second Play press -> IDLE, mem_raddr=0, tick stays 0.
- **Full:** 7 Store presses from empty -> 6 mem_we pulses at addresses 0..5, 7th produces none, length=6, full=1; Play with empty=1 from reset -> state stays IDLE, display_en=0.
- **Collisions:** Store and Play pins fall on the same edge in IDLE with length=2 -> write at address 2, length=3, state remains IDLE.
- **Append during play:** Store during PLAY with length=3 -> append at address 3; mem_raddr then cycles 0..3.
